// File: rtl/fifo_drain_tx.sv
// Drains a show-ahead byte FIFO onto an async serial line as LSB-first 8-bit frames (start, data, optional even parity, stop).
// Latency: one IDLE fetch cycle from a non-empty FIFO to the start bit; frame = (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT clks.
// Backpressure: pops only in IDLE while tx_en=1 and the FIFO is non-empty; a frame in flight always runs to completion.
module fifo_drain_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Last count value of one bit period; the counter restarts at every bit boundary.
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  // The bit index doubles as the stop-bit counter while in STOP.
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [2:0]  DATA_LAST = 3'd7;

  state_t      state, state_nxt;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        par_bit, par_nxt;
  logic        tx_nxt;
  logic        baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE);

  // Next-state, datapath and strobe decode for the frame sequencer.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud_cnt + 16'd1;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    par_nxt     = par_bit;
    fifo_rd     = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        baud_nxt = 16'd0;
        // Reset gates the pop so a FIFO never loses a byte while we are held in reset.
        fifo_rd  = tx_en & ~fifo_empty & ~rst;
        if (fifo_rd) begin
          shreg_nxt   = fifo_dout;
          par_nxt     = ^fifo_dout;
          bit_idx_nxt = 3'd0;
          state_nxt   = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_nxt    = 16'd0;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_nxt  = 16'd0;
          shreg_nxt = {1'b0, shreg[7:1]};
          if (bit_idx == DATA_LAST) begin
            bit_idx_nxt = 3'd0;
            state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (baud_last) begin
          baud_nxt    = 16'd0;
          bit_idx_nxt = 3'd0;
          state_nxt   = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_nxt = 16'd0;
          if (bit_idx == STOP_LAST) begin
            frame_done  = 1'b1;
            bit_idx_nxt = 3'd0;
            state_nxt   = IDLE;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        baud_nxt    = 16'd0;
        bit_idx_nxt = 3'd0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from where the sequencer is headed so tx stays registered.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  // Sequencer state, bit timing and shift register; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      par_bit  <= par_nxt;
      tx       <= tx_nxt;
    end
  end

  // Completed-frame counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count <= 16'd0;
    end else if (frame_done) begin
      byte_count <= byte_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Directed bench: DUT a (4 clks/bit, no parity) and DUT b (4 clks/bit, even parity) each fed by a queue-backed show-ahead FIFO.
// Inputs change and outputs are sampled 1 time unit after the falling edge; FIFO pops are applied just after the rising edge.
// Frame waveforms are collected one sample per clk into a vector, oldest sample in the highest bit.
module tb_fifo_drain_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_tx_en, a_empty, a_rd, a_tx, a_busy, a_done;
  logic [7:0]  a_dout;
  logic [15:0] a_cnt;
  logic        b_rst, b_tx_en, b_empty, b_rd, b_tx, b_busy, b_done;
  logic [7:0]  b_dout;
  logic [15:0] b_cnt;

  fifo_drain_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(a_rst), .tx_en(a_tx_en), .fifo_empty(a_empty), .fifo_dout(a_dout),
    .fifo_rd(a_rd), .tx(a_tx), .busy(a_busy), .frame_done(a_done), .byte_count(a_cnt));

  fifo_drain_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(b_rst), .tx_en(b_tx_en), .fifo_empty(b_empty), .fifo_dout(b_dout),
    .fifo_rd(b_rd), .tx(b_tx), .busy(b_busy), .frame_done(b_done), .byte_count(b_cnt));

  logic [7:0]  a_q[$];
  logic [7:0]  b_q[$];
  logic [63:0] a_txv, b_txv;
  int a_rd_n, a_done_n, a_busy_n, a_low_n, a_idx;
  int b_rd_n, b_done_n, b_busy_n, b_idx;
  int a_pos[$];
  int b_pos[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic a_refresh();
    a_empty = (a_q.size() == 0);
    a_dout  = a_empty ? 8'h00 : a_q[0];
  endtask

  task automatic b_refresh();
    b_empty = (b_q.size() == 0);
    b_dout  = b_empty ? 8'h00 : b_q[0];
  endtask

  task automatic a_push(input logic [7:0] d);
    a_q.push_back(d);
    a_refresh();
  endtask

  task automatic b_push(input logic [7:0] d);
    b_q.push_back(d);
    b_refresh();
  endtask

  task automatic clr_mon();
    a_txv = 64'd0; a_rd_n = 0; a_done_n = 0; a_busy_n = 0; a_low_n = 0; a_idx = 0;
    b_txv = 64'd0; b_rd_n = 0; b_done_n = 0; b_busy_n = 0; b_idx = 0;
    a_pos.delete();
    b_pos.delete();
  endtask

  function automatic int a_pos_at(input int k);
    return (k < a_pos.size()) ? a_pos[k] : -1;
  endfunction

  function automatic int b_pos_at(input int k);
    return (k < b_pos.size()) ? b_pos[k] : -1;
  endfunction

  // Called at a falling edge; runs n clocks, sampling both DUTs once per clk and servicing pops.
  task automatic run(input int n);
    logic ra, rb;
    for (int i = 0; i < n; i++) begin
      #1;
      a_txv = {a_txv[62:0], a_tx};
      a_rd_n += int'(a_rd); a_done_n += int'(a_done); a_busy_n += int'(a_busy); a_low_n += int'(!a_tx);
      if (a_done) a_pos.push_back(a_idx);
      a_idx++;
      b_txv = {b_txv[62:0], b_tx};
      b_rd_n += int'(b_rd); b_done_n += int'(b_done); b_busy_n += int'(b_busy);
      if (b_done) b_pos.push_back(b_idx);
      b_idx++;
      ra = a_rd;
      rb = b_rd;
      @(posedge clk);
      #1;
      if (ra && a_q.size() > 0) begin void'(a_q.pop_front()); a_refresh(); end
      if (rb && b_q.size() > 0) begin void'(b_q.pop_front()); b_refresh(); end
      @(negedge clk);
    end
  endtask

  initial begin
    a_rst = 1'b1; a_tx_en = 1'b0; a_empty = 1'b1; a_dout = 8'h00;
    b_rst = 1'b1; b_tx_en = 1'b0; b_empty = 1'b1; b_dout = 8'h00;
    clr_mon();
    @(negedge clk);
    #1;
    chk("rst_tx", a_tx, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_count", a_cnt, 0);

    // Data queued and permission given while still in reset: no pop may happen.
    a_push(8'hA5);
    a_tx_en = 1'b1;
    clr_mon();
    run(2);
    chk("rd_held_in_rst", a_rd_n, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Single 0xA5 frame: idle fetch cycle then 0,1,0,1,0,0,1,0,1,1 at 4 clks per bit.
    clr_mon();
    run(41);
    chk("a5_wave", a_txv, 64'h10F0F00F0FF);
    chk("a5_rd_pulses", a_rd_n, 1);
    chk("a5_done_pulses", a_done_n, 1);
    chk("a5_done_pos", a_pos_at(0), 40);
    chk("a5_busy_clks", a_busy_n, 40);
    chk("a5_count", a_cnt, 1);
    chk("a5_idle_tx", a_tx, 1);

    // Three queued bytes back to back: frames end at samples 40, 81, 122 (one idle clk between).
    a_push(8'h11); a_push(8'h22); a_push(8'h33);
    clr_mon();
    run(123);
    chk("b2b_rd_pulses", a_rd_n, 3);
    chk("b2b_done_pulses", a_done_n, 3);
    chk("b2b_done_pos0", a_pos_at(0), 40);
    chk("b2b_done_pos1", a_pos_at(1), 81);
    chk("b2b_done_pos2", a_pos_at(2), 122);
    chk("b2b_busy_clks", a_busy_n, 120);
    chk("b2b_count", a_cnt, 4);
    chk("b2b_fifo_left", a_q.size(), 0);

    // tx_en dropped during DATA of 0x5A: frame completes, 0xC3 waits until tx_en returns.
    a_push(8'h5A); a_push(8'hC3);
    clr_mon();
    run(13);
    a_tx_en = 1'b0;
    run(28);
    chk("txen_wave_5a", a_txv, 64'h100F0FF0F0F);
    chk("txen_done", a_done_n, 1);
    clr_mon();
    run(20);
    chk("txen_no_pop", a_rd_n, 0);
    chk("txen_no_busy", a_busy_n, 0);
    chk("txen_fifo_left", a_q.size(), 1);
    chk("txen_count", a_cnt, 5);
    a_tx_en = 1'b1;
    clr_mon();
    run(41);
    chk("txen_wave_c3", a_txv, 64'h10FF0000FFF);
    chk("txen_rd_after", a_rd_n, 1);
    chk("txen_count2", a_cnt, 6);

    // Reset in the first cycle of DATA bit 3 of 0x96 (bit 3 is 0); 0x3C stays queued.
    a_push(8'h96); a_push(8'h3C);
    clr_mon();
    run(17);
    #1;
    chk("mid_tx_bit3", a_tx, 0);
    a_rst = 1'b1;
    #1;
    chk("mid_rst_tx", a_tx, 1);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_count", a_cnt, 0);
    @(negedge clk);
    clr_mon();
    run(3);
    chk("mid_rst_no_pop", a_rd_n, 0);
    chk("mid_rst_fifo_left", a_q.size(), 1);
    a_rst = 1'b0;
    clr_mon();
    run(41);
    chk("mid_wave_3c", a_txv, 64'h1000FFFF00F);
    chk("mid_count_after", a_cnt, 1);

    // Empty FIFO with permission for 100 clks: line stays idle.
    clr_mon();
    run(100);
    chk("empty_rd", a_rd_n, 0);
    chk("empty_busy", a_busy_n, 0);
    chk("empty_tx_low", a_low_n, 0);

    // Parity build: 0x07 -> parity 1, 0x03 -> parity 0, 44-clk frames.
    b_push(8'h07); b_push(8'h03);
    b_tx_en = 1'b1;
    clr_mon();
    run(45);
    chk("par07_wave", b_txv, 64'h10FFF00000FF);
    chk("par07_done_pos", b_pos_at(0), 44);
    chk("par07_busy_clks", b_busy_n, 44);
    chk("par07_rd", b_rd_n, 1);
    clr_mon();
    run(45);
    chk("par03_wave", b_txv, 64'h10FF0000000F);
    chk("par03_done_pos", b_pos_at(0), 44);
    chk("par_count", b_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
